// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared types and sizes for the cache controller
package cache_controller_pkg;

    localparam int ADDR_WIDTH  = 6;
    localparam int DATA_WIDTH  = 8;
    localparam int INDEX_WIDTH = 3;
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;
    localparam int NUM_LINES   = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        Op_INVALID = 2'd0,
        Op_READ    = 2'd1,
        Op_WRITE   = 2'd2
    } Op;

    typedef logic [ADDR_WIDTH-1:0]  UbitAddr;
    typedef logic [DATA_WIDTH-1:0]  UbitData;
    typedef logic [INDEX_WIDTH-1:0] UbitIndex;
    typedef logic [TAG_WIDTH-1:0]   UbitTag;

    typedef struct packed {
        logic    valid;
        logic    dirty;
        UbitTag  tag;
        UbitData data;
    } Line;

    typedef enum logic [1:0] {
        State_READY     = 2'd0,
        State_WRITEBACK = 2'd1,
        State_FILL_WAIT = 2'd2
    } State;

    function automatic UbitIndex addr_index(input UbitAddr addr);
        return addr[INDEX_WIDTH-1:0];
    endfunction

    function automatic UbitTag addr_tag(input UbitAddr addr);
        return addr[ADDR_WIDTH-1:INDEX_WIDTH];
    endfunction

endpackage

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back write-allocate cache, one-word lines
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cpu_req_op,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_data,
    output logic                  cpu_req_rdy,
    output logic                  cpu_rsp_vld,
    output logic [DATA_WIDTH-1:0] cpu_rsp_data,
    output logic [1:0]            mem_req_op,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_rsp_vld,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

    State    state_q, state_d;
    Line     lines_q [NUM_LINES];
    Line     lines_d [NUM_LINES];

    // Request captured at acceptance; needed once the miss leaves READY.
    Op       req_op_q, req_op_d;
    UbitAddr req_addr_q, req_addr_d;
    UbitData req_data_q, req_data_d;

    Op       mem_op_q, mem_op_d;
    UbitAddr mem_addr_q, mem_addr_d;
    UbitData mem_data_q, mem_data_d;
    logic    rsp_vld_q, rsp_vld_d;
    UbitData rsp_data_q, rsp_data_d;

    Op        in_op;
    logic     in_valid;
    UbitIndex in_idx;
    Line      in_line;
    logic     in_hit;

    // Shared "victim is out of the way" step, reached from READY or WRITEBACK.
    logic     do_exit;
    Op        ex_op;
    UbitAddr  ex_addr;
    UbitData  ex_data;

    assign in_op    = Op'(cpu_req_op);
    assign in_valid = (in_op == Op_READ) || (in_op == Op_WRITE);
    assign in_idx   = addr_index(cpu_req_addr);
    assign in_line  = lines_q[in_idx];
    assign in_hit   = in_line.valid && (in_line.tag == addr_tag(cpu_req_addr));

    assign cpu_req_rdy  = (state_q == State_READY);
    assign cpu_rsp_vld  = rsp_vld_q;
    assign cpu_rsp_data = rsp_data_q;
    assign mem_req_op   = mem_op_q;
    assign mem_req_addr = mem_addr_q;
    assign mem_req_data = mem_data_q;

    // Next-state, line updates and registered outputs for the miss-handling FSM.
    always_comb begin
        state_d    = state_q;
        lines_d    = lines_q;
        req_op_d   = req_op_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        mem_op_d   = Op_INVALID;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rsp_vld_d  = 1'b0;
        rsp_data_d = rsp_data_q;
        do_exit    = 1'b0;
        ex_op      = req_op_q;
        ex_addr    = req_addr_q;
        ex_data    = req_data_q;

        case (state_q)
            State_READY: begin
                if (in_valid) begin
                    req_op_d   = in_op;
                    req_addr_d = cpu_req_addr;
                    req_data_d = cpu_req_data;
                    if (in_hit) begin
                        if (in_op == Op_READ) begin
                            rsp_data_d = in_line.data;
                            rsp_vld_d  = 1'b1;
                        end else begin
                            lines_d[in_idx].data  = cpu_req_data;
                            lines_d[in_idx].dirty = 1'b1;
                        end
                    end else if (in_line.valid && in_line.dirty) begin
                        mem_op_d   = Op_WRITE;
                        mem_addr_d = {in_line.tag, in_idx};
                        mem_data_d = in_line.data;
                        state_d    = State_WRITEBACK;
                    end else begin
                        do_exit = 1'b1;
                        ex_op   = in_op;
                        ex_addr = cpu_req_addr;
                        ex_data = cpu_req_data;
                    end
                end
            end
            State_WRITEBACK: begin
                do_exit = 1'b1;
            end
            State_FILL_WAIT: begin
                if (mem_rsp_vld) begin
                    lines_d[addr_index(req_addr_q)] = '{valid: 1'b1, dirty: 1'b0,
                                                        tag: addr_tag(req_addr_q),
                                                        data: mem_rsp_data};
                    rsp_data_d = mem_rsp_data;
                    rsp_vld_d  = 1'b1;
                    state_d    = State_READY;
                end
            end
            default: begin
                state_d = State_READY;
            end
        endcase

        // Read misses fetch the word; write misses just install it (one-word lines).
        if (do_exit) begin
            if (ex_op == Op_READ) begin
                mem_op_d   = Op_READ;
                mem_addr_d = ex_addr;
                state_d    = State_FILL_WAIT;
            end else begin
                lines_d[addr_index(ex_addr)] = '{valid: 1'b1, dirty: 1'b1,
                                                 tag: addr_tag(ex_addr),
                                                 data: ex_data};
                state_d = State_READY;
            end
        end
    end

    // State, line array and output registers; reset drops any miss in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= State_READY;
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_q[i] <= '0;
            end
            req_op_q   <= Op_INVALID;
            req_addr_q <= '0;
            req_data_q <= '0;
            mem_op_q   <= Op_INVALID;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lines_q    <= lines_d;
            req_op_q   <= req_op_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            mem_op_q   <= mem_op_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller
module tb_cache_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cpu_req_op;
    logic [5:0] cpu_req_addr;
    logic [7:0] cpu_req_data;
    logic       cpu_req_rdy;
    logic       cpu_rsp_vld;
    logic [7:0] cpu_rsp_data;
    logic [1:0] mem_req_op;
    logic [5:0] mem_req_addr;
    logic [7:0] mem_req_data;
    logic       mem_rsp_vld = 1'b0;
    logic [7:0] mem_rsp_data = 8'h00;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_op   (cpu_req_op),
        .cpu_req_addr (cpu_req_addr),
        .cpu_req_data (cpu_req_data),
        .cpu_req_rdy  (cpu_req_rdy),
        .cpu_rsp_vld  (cpu_rsp_vld),
        .cpu_rsp_data (cpu_rsp_data),
        .mem_req_op   (mem_req_op),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_data (mem_rsp_data)
    );

    // Memory: always ready, read data one cycle after the request cycle.
    logic [7:0] env_mem [64];
    logic       env_init = 1'b0;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 64; i++) env_mem[i] = 8'h00;
            env_init = 1'b1;
        end
        mem_rsp_vld <= 1'b0;
        if (mem_req_op == 2'd1) begin
            mem_rsp_vld  <= 1'b1;
            mem_rsp_data <= env_mem[mem_req_addr];
        end else if (mem_req_op == 2'd2) begin
            env_mem[mem_req_addr] = mem_req_data;
        end
    end

    // Reference model: cache contents plus an expected-output schedule per cycle.
    localparam int NL = 1024;
    int         ecount = 0;
    int         busy_last = -1;
    int         acc_label = -1;
    int         acc_seen = 0;
    logic       m_init = 1'b0;
    logic       m_valid [8];
    logic       m_dirty [8];
    logic [2:0] m_tag   [8];
    logic [7:0] m_data  [8];
    logic [7:0] ref_mem [64];
    logic       e_rdy   [NL];
    logic       e_vld   [NL];
    logic [7:0] e_rdata [NL];
    logic [1:0] e_op    [NL];
    logic [5:0] e_addr  [NL];
    logic [7:0] e_wdata [NL];
    int         m_c, m_k;
    logic [5:0] m_a, m_vaddr;
    logic [7:0] m_wd;
    logic [2:0] m_i, m_t;

    always @(posedge clk) begin
        if (!m_init) begin
            for (int l = 0; l < NL; l++) begin
                e_rdy[l] = 1'b1; e_vld[l] = 1'b0; e_rdata[l] = 8'h00;
                e_op[l] = 2'd0; e_addr[l] = 6'h00; e_wdata[l] = 8'h00;
            end
            for (int j = 0; j < 64; j++) ref_mem[j] = 8'h00;
            for (int j = 0; j < 8; j++) begin
                m_valid[j] = 1'b0; m_dirty[j] = 1'b0; m_tag[j] = 3'd0; m_data[j] = 8'h00;
            end
            m_init = 1'b1;
        end
        ecount = ecount + 1;
        if (rst) begin
            for (int j = 0; j < 8; j++) begin
                m_valid[j] = 1'b0; m_dirty[j] = 1'b0;
            end
            for (int l = ecount; l < NL; l++) begin
                e_rdy[l] = 1'b1; e_vld[l] = 1'b0; e_op[l] = 2'd0;
            end
            busy_last = -1;
        end else if ((cpu_req_op == 2'd1 || cpu_req_op == 2'd2) && busy_last < ecount - 1
                     && ecount + 4 < NL) begin
            m_c  = ecount;
            m_a  = cpu_req_addr;
            m_wd = cpu_req_data;
            m_i  = m_a[2:0];
            m_t  = m_a[5:3];
            if (m_valid[m_i] && m_tag[m_i] == m_t) begin
                if (cpu_req_op == 2'd1) begin
                    e_vld[m_c] = 1'b1; e_rdata[m_c] = m_data[m_i];
                end else begin
                    m_data[m_i] = m_wd; m_dirty[m_i] = 1'b1;
                end
            end else begin
                m_k = 0;
                if (m_valid[m_i] && m_dirty[m_i]) begin
                    m_vaddr = {m_tag[m_i], m_i};
                    e_op[m_c] = 2'd2; e_addr[m_c] = m_vaddr; e_wdata[m_c] = m_data[m_i];
                    ref_mem[m_vaddr] = m_data[m_i];
                    m_k = 1;
                end
                if (cpu_req_op == 2'd1) begin
                    e_op[m_c + m_k] = 2'd1; e_addr[m_c + m_k] = m_a;
                    e_vld[m_c + m_k + 2] = 1'b1; e_rdata[m_c + m_k + 2] = ref_mem[m_a];
                    for (int l = m_c; l <= m_c + m_k + 1; l++) e_rdy[l] = 1'b0;
                    busy_last = m_c + m_k + 1;
                    m_valid[m_i] = 1'b1; m_dirty[m_i] = 1'b0; m_tag[m_i] = m_t; m_data[m_i] = ref_mem[m_a];
                end else begin
                    m_valid[m_i] = 1'b1; m_dirty[m_i] = 1'b1; m_tag[m_i] = m_t; m_data[m_i] = m_wd;
                    if (m_k == 1) begin
                        e_rdy[m_c] = 1'b0; busy_last = m_c;
                    end
                end
            end
            acc_label = m_c;
            acc_seen  = acc_seen + 1;
        end
    end

    int   checks = 0;
    int   failures = 0;
    logic checking = 1'b0;
    int   rsp_cnt, rd_cnt, wr_cnt, rdy_low;
    int   obs_rsp_label, obs_rd_label, obs_wr_label;
    logic [7:0] obs_rsp_data, obs_wr_data;
    logic [5:0] obs_rd_addr, obs_wr_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, ecount);
        end
    endtask

    task automatic clear_obs();
        rsp_cnt = 0; rd_cnt = 0; wr_cnt = 0; rdy_low = 0;
        obs_rsp_label = -1; obs_rd_label = -1; obs_wr_label = -1;
        obs_rsp_data = 8'h00; obs_wr_data = 8'h00; obs_rd_addr = 6'h00; obs_wr_addr = 6'h00;
    endtask

    // One cycle: sample away from the edge and compare against the schedule.
    task automatic tick();
        int l;
        @(negedge clk);
        l = ecount;
        if (checking && l < NL) begin
            chk("cpu_req_rdy", cpu_req_rdy, e_rdy[l]);
            chk("cpu_rsp_vld", cpu_rsp_vld, e_vld[l]);
            if (e_vld[l]) chk("cpu_rsp_data", cpu_rsp_data, e_rdata[l]);
            chk("mem_req_op", mem_req_op, e_op[l]);
            if (e_op[l] != 2'd0) chk("mem_req_addr", mem_req_addr, e_addr[l]);
            if (e_op[l] == 2'd2) chk("mem_req_data", mem_req_data, e_wdata[l]);
        end
        if (cpu_rsp_vld === 1'b1) begin
            rsp_cnt = rsp_cnt + 1; obs_rsp_label = l; obs_rsp_data = cpu_rsp_data;
        end
        if (mem_req_op === 2'd1) begin
            rd_cnt = rd_cnt + 1; obs_rd_label = l; obs_rd_addr = mem_req_addr;
        end
        if (mem_req_op === 2'd2) begin
            wr_cnt = wr_cnt + 1; obs_wr_label = l; obs_wr_addr = mem_req_addr; obs_wr_data = mem_req_data;
        end
        if (cpu_req_rdy !== 1'b1) rdy_low = rdy_low + 1;
    endtask

    // Present a request and hold it until the model says it was taken.
    task automatic do_req(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d,
                          output int acc);
        int n0;
        n0 = acc_seen;
        cpu_req_op = op; cpu_req_addr = a; cpu_req_data = d;
        for (int k = 0; k < 50 && acc_seen == n0; k++) tick();
        if (acc_seen == n0) begin
            chk("accept_timeout", 32'd0, 32'd1);
            acc = -1;
        end else begin
            acc = acc_label;
        end
        cpu_req_op = 2'd0;
    endtask

    int acc, acc2;

    initial begin
        rst = 1'b1; cpu_req_op = 2'd0; cpu_req_addr = 6'h00; cpu_req_data = 8'h00;
        clear_obs();
        repeat (3) @(negedge clk);
        chk("reset_rdy", cpu_req_rdy, 1);
        chk("reset_rsp_vld", cpu_rsp_vld, 0);
        chk("reset_rsp_data", cpu_rsp_data, 0);
        chk("reset_mem_op", mem_req_op, 0);
        chk("reset_mem_addr", mem_req_addr, 0);
        chk("reset_mem_data", mem_req_data, 0);
        rst = 1'b0;
        checking = 1'b1;
        repeat (2) tick();

        // Cold read miss
        clear_obs();
        do_req(2'd1, 6'h05, 8'h00, acc);
        repeat (5) tick();
        chk("cold_rd_cnt", rd_cnt, 1);
        chk("cold_rd_addr", obs_rd_addr, 6'h05);
        chk("cold_rd_cycle", obs_rd_label - acc, 0);
        chk("cold_latency", obs_rsp_label - acc + 1, 3);
        chk("cold_data", obs_rsp_data, 8'h00);
        chk("cold_rdy_low", rdy_low, 2);

        // Write hit then read hit
        clear_obs();
        do_req(2'd2, 6'h05, 8'hAB, acc);
        repeat (2) tick();
        do_req(2'd1, 6'h05, 8'h00, acc);
        repeat (3) tick();
        chk("hit_latency", obs_rsp_label - acc + 1, 1);
        chk("hit_data", obs_rsp_data, 8'hAB);
        chk("hit_mem_traffic", rd_cnt + wr_cnt, 0);

        // Dirty read miss
        clear_obs();
        do_req(2'd1, 6'h0D, 8'h00, acc);
        repeat (6) tick();
        chk("dirty_wr_addr", obs_wr_addr, 6'h05);
        chk("dirty_wr_data", obs_wr_data, 8'hAB);
        chk("dirty_wr_cycle", obs_wr_label - acc, 0);
        chk("dirty_rd_cycle", obs_rd_label - acc, 1);
        chk("dirty_rd_addr", obs_rd_addr, 6'h0D);
        chk("dirty_latency", obs_rsp_label - acc + 1, 4);
        chk("dirty_data", obs_rsp_data, 8'h00);

        // Dirty write miss
        do_req(2'd2, 6'h0D, 8'h11, acc);
        repeat (2) tick();
        clear_obs();
        do_req(2'd2, 6'h15, 8'h3C, acc);
        repeat (4) tick();
        chk("wmiss_wr_cnt", wr_cnt, 1);
        chk("wmiss_wr_addr", obs_wr_addr, 6'h0D);
        chk("wmiss_wr_data", obs_wr_data, 8'h11);
        chk("wmiss_rd_cnt", rd_cnt, 0);
        chk("wmiss_rsp_cnt", rsp_cnt, 0);
        chk("wmiss_rdy_low", rdy_low, 1);
        clear_obs();
        do_req(2'd1, 6'h15, 8'h00, acc);
        repeat (3) tick();
        chk("wmiss_read_latency", obs_rsp_label - acc + 1, 1);
        chk("wmiss_read_data", obs_rsp_data, 8'h3C);

        // Reset during FILL_WAIT
        clear_obs();
        do_req(2'd1, 6'h2A, 8'h00, acc);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_rsp_cnt", rsp_cnt, 0);
        chk("abort_rdy", cpu_req_rdy, 1);
        clear_obs();
        do_req(2'd1, 6'h05, 8'h00, acc);
        repeat (5) tick();
        chk("abort_remiss_rd_cnt", rd_cnt, 1);
        chk("abort_remiss_latency", obs_rsp_label - acc + 1, 3);
        chk("abort_remiss_data", obs_rsp_data, 8'hAB);

        // Back-pressure: second read held while the first misses
        clear_obs();
        do_req(2'd1, 6'h25, 8'h00, acc);
        do_req(2'd1, 6'h05, 8'h00, acc2);
        repeat (5) tick();
        chk("bp_accept_gap", acc2 - acc, 3);
        chk("bp_rsp_cnt", rsp_cnt, 2);
        chk("bp_latency", obs_rsp_label - acc2 + 1, 3);
        chk("bp_data", obs_rsp_data, 8'hAB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache with one-word lines.
- Sits between a CPU-side request port and the memory model, and acts as the initiator on the memory bus: it drives req_op/req_addr/req_data and consumes rsp_vld/rsp_data.
- Serves hits locally. Misses are handled with an optional victim writeback followed by a fill read.

Parameters:
- ADDR_WIDTH, 6, word address width; must match the memory model.
- DATA_WIDTH, 8, word width.
- INDEX_WIDTH, 3, line index width; 1<<INDEX_WIDTH lines; tag width = ADDR_WIDTH-INDEX_WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- cpu_req_op  input  2  Op_INVALID / Op_READ / Op_WRITE; sampled only when cpu_req_rdy=1.
- cpu_req_addr  input  ADDR_WIDTH  request address.
- cpu_req_data  input  DATA_WIDTH  write data.
- cpu_req_rdy  output  1  high when a request can be accepted.
- cpu_rsp_vld  output  1  one-cycle pulse for read completion only.
- cpu_rsp_data  output  DATA_WIDTH  read data; valid while cpu_rsp_vld=1.
- mem_req_op  output  2  memory op; a non-INVALID value is held for exactly one cycle.
- mem_req_addr  output  ADDR_WIDTH  memory address.
- mem_req_data  output  DATA_WIDTH  memory write data.
- mem_rsp_vld  input  1  memory read response strobe, one cycle after the read request cycle.
- mem_rsp_data  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset:
  - state=READY.
  - All line valid/dirty bits cleared. Tag/data contents don't-care.
  - cpu_rsp_vld=0, cpu_rsp_data=0, mem_req_op=Op_INVALID, mem_req_addr=0, mem_req_data=0.
  - Reset aborts any miss in progress; no response is produced for the aborted request.
- Outputs are registered. mem_req_op and cpu_rsp_vld default to INVALID/0 every cycle (pulses).
- cpu_req_rdy = (state==READY), combinational from state.
- Request acceptance: at an edge with cpu_req_rdy=1 and cpu_req_op!=INVALID, the request is latched (op, addr, data). index=addr[INDEX_WIDTH-1:0], tag=upper bits. hit = valid[index] && tag match.
- Hit, in READY:
  - Read: cpu_rsp_data<=line data, cpu_rsp_vld<=1, i.e. 1-cycle latency.
  - Write: line data<=cpu_req_data, dirty<=1; no response, no memory traffic.
- Miss with victim valid and dirty:
  - mem_req_op<=Op_WRITE, mem_req_addr<={victim tag,index}, mem_req_data<=victim data.
  - Go to WRITEBACK.
- Miss with victim clean or invalid: handled as in WRITEBACK exit below, directly from READY.
- WRITEBACK exit:
  - Read miss: mem_req_op<=Op_READ, mem_req_addr<=latched addr; go to FILL_WAIT.
  - Write miss: install line (valid=1, dirty=1, tag, data=latched data); go to READY. No fill is needed because lines are one word.
- FILL_WAIT:
  - Waits for mem_rsp_vld.
  - On mem_rsp_vld: install line (valid=1, dirty=0, tag, data=mem_rsp_data), cpu_rsp_data<=mem_rsp_data, cpu_rsp_vld<=1; go to READY.
- Read latency (cpu_rsp_vld high N cycles after the acceptance edge): hit 1, clean miss 3, dirty miss 4.
- Write miss: clean installs with no bus traffic and cpu_req_rdy never drops; dirty drops cpu_req_rdy for 1 cycle (1 memory write).
- mem_rsp_vld outside FILL_WAIT is ignored.
- CPU requests presented while cpu_req_rdy=0 are ignored; the CPU holds the request until accepted.
- The memory always accepts requests, so there is no memory-side ready.

Decomposition:
- Shared package (existing): Op enum (Op_INVALID, Op_READ, Op_WRITE), ADDR_WIDTH, UbitAddr, UbitData.
- Additions to the package:
  - INDEX_WIDTH, TAG_WIDTH.
  - Typedefs UbitIndex, UbitTag.
  - Struct Line {valid, dirty, tag, data}.
  - State enum State_READY / State_WRITEBACK / State_FILL_WAIT.
- Line storage stays inline as an array of Line. No sub-module is warranted.

Test Plan:
- Cold read miss: reset, read 0x05 -> mem READ 0x05 one cycle after accept; cpu_rsp_vld with 0x00 at +3; cpu_req_rdy low for 2 cycles.
- Write hit, then read hit: write 0x05=0xAB (hit, since line 5 is filled) then read 0x05 -> cpu_rsp 0xAB at +1; mem_req_op stays INVALID throughout.
- Dirty read miss: after the previous scenario, read 0x0D (index 5) -> mem WRITE addr 0x05 data 0xAB, next cycle mem READ 0x0D; cpu_rsp 0x00 at +4.
- Dirty write miss: write 0x0D=0x11 (hit), then write 0x15=0x3C -> mem WRITE 0x0D data 0x11, no mem READ, no cpu_rsp. Then read 0x15 -> 0x3C at +1.
- Reset mid-miss: read 0x2A, assert rst in FILL_WAIT -> no cpu_rsp_vld; cpu_req_rdy=1 after reset; read 0x05 misses again.
- Busy back-pressure: hold read 0x05 during a miss -> accepted only once cpu_req_rdy=1; exactly one response is produced.
